// File: rtl/axi_burst_master_stream.sv
// AXI4 burst master: splits one user command into INCR bursts that never cross a
// 4 KB page and streams write/read beats between user valid/ready ports and the slave.
`timescale 1ns/1ps
module axi_burst_master_stream #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 256,
    parameter int WRITE_EN  = 1,
    parameter int READ_EN   = 1
) (
    input  logic                aclk,
    input  logic                areset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_w_r,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [15:0]         cmd_beats,

    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,

    output logic [DATA_W-1:0]   m_rdata,
    output logic                m_rvalid,
    input  logic                m_rready,
    output logic                m_rlast,

    output logic                done,
    output logic [1:0]          done_resp,
    output logic                busy,
    output logic [2:0]          dbg_state,

    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awcache,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awqos,
    output logic [3:0]          m_axi_awregion,

    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    output logic                m_axi_wlast,
    input  logic                m_axi_wready,

    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,

    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arcache,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arqos,
    output logic [3:0]          m_axi_arregion,

    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    input  logic                m_axi_rlast,
    output logic                m_axi_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               w_r_q;
    logic [16:0]        remaining_q;
    logic [8:0]         blen_q;
    logic [8:0]         beat_q;
    logic [1:0]         resp_q;
    logic [ADDR_W-1:0]  axaddr_q;
    logic [7:0]         axlen_q;

    logic [16:0]        to_4k;
    logic [16:0]        blen_calc;
    logic               w_hs, r_hs, b_hs;
    logic               last_beat, final_burst, path_off;

    // A transfer happens on a cycle where both valid and ready are high at the
    // clock edge; a valid, once raised, holds with its payload until that cycle.
    assign w_hs        = (state_q == S_W) && s_wvalid && m_axi_wready;
    assign r_hs        = (state_q == S_R) && m_axi_rvalid && m_rready;
    assign b_hs        = (state_q == S_B) && m_axi_bvalid;
    assign last_beat   = (beat_q == blen_q - 9'd1);
    assign final_burst = (remaining_q == {8'd0, blen_q});
    assign path_off    = w_r_q ? (READ_EN == 0) : (WRITE_EN == 0);

    // Burst length: smallest of what is left, the burst cap and beats to the page end.
    always_comb begin
        to_4k     = (17'd4096 - {5'd0, addr_q[11:0]}) >> SIZE;
        blen_calc = remaining_q;
        if (blen_calc > 17'(MAX_BURST)) blen_calc = 17'(MAX_BURST);
        if (blen_calc > to_4k)          blen_calc = to_4k;
    end

    always_ff @(posedge aclk) begin
        if (areset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_CALC;
            S_CALC: begin
                if (path_off)   state_d = S_DONE;
                else if (w_r_q) state_d = S_AR;
                else            state_d = S_AW;
            end
            S_AW:    if (m_axi_awready) state_d = S_W;
            S_W:     if (w_hs && last_beat) state_d = S_B;
            S_B:     if (b_hs) state_d = final_burst ? S_DONE : S_CALC;
            S_AR:    if (m_axi_arready) state_d = S_R;
            S_R:     if (r_hs && m_axi_rlast) state_d = final_burst ? S_DONE : S_CALC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q      <= '0;
            w_r_q       <= 1'b0;
            remaining_q <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
            resp_q      <= 2'b00;
            axaddr_q    <= '0;
            axlen_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    addr_q      <= cmd_addr & ~ALIGN_MASK;
                    w_r_q       <= cmd_w_r;
                    remaining_q <= {1'b0, cmd_beats} + 17'd1;
                    resp_q      <= 2'b00;
                end
                S_CALC: begin
                    blen_q   <= 9'(blen_calc);
                    axlen_q  <= 8'(blen_calc - 17'd1);
                    axaddr_q <= addr_q;
                    beat_q   <= '0;
                    if (path_off) resp_q <= 2'b10;
                end
                S_W: if (w_hs) beat_q <= beat_q + 9'd1;
                S_B: if (b_hs) begin
                    if (!resp_q[1] && m_axi_bresp[1]) resp_q <= m_axi_bresp;
                    addr_q      <= addr_q + (ADDR_W'(blen_q) << SIZE);
                    remaining_q <= remaining_q - {8'd0, blen_q};
                end
                // First SLVERR/DECERR wins; EXOKAY leaves the OKAY status untouched.
                S_R: if (r_hs) begin
                    if (!resp_q[1] && m_axi_rresp[1]) resp_q <= m_axi_rresp;
                    if (m_axi_rlast) begin
                        addr_q      <= addr_q + (ADDR_W'(blen_q) << SIZE);
                        remaining_q <= remaining_q - {8'd0, blen_q};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready     = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        done_resp     = done ? resp_q : 2'b00;
        m_axi_awvalid = (state_q == S_AW);
        m_axi_wvalid  = (state_q == S_W) && s_wvalid;
        s_wready      = (state_q == S_W) && m_axi_wready;
        m_axi_wlast   = (state_q == S_W) && last_beat;
        m_axi_bready  = (state_q == S_B);
        m_axi_arvalid = (state_q == S_AR);
        m_rvalid      = (state_q == S_R) && m_axi_rvalid;
        m_axi_rready  = (state_q == S_R) && m_rready;
        m_rlast       = (state_q == S_R) && m_axi_rlast && final_burst;
    end

    assign dbg_state      = state_q;
    assign m_rdata        = m_axi_rdata;
    assign m_axi_wdata    = s_wdata;
    assign m_axi_wstrb    = s_wstrb;

    assign m_axi_awaddr   = axaddr_q;
    assign m_axi_awlen    = axlen_q;
    assign m_axi_awsize   = 3'(SIZE);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awprot   = 3'd0;
    assign m_axi_awcache  = 4'd0;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;

    assign m_axi_araddr   = axaddr_q;
    assign m_axi_arlen    = axlen_q;
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arprot   = 3'd0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;

endmodule

// File: tb/tb_axi_burst_master_stream.sv
// Bench for axi_burst_master_stream: behavioural AXI slave and user streams,
// with results compared against a burst-splitting reference model.
`timescale 1ns/1ps
module tb_axi_burst_master_stream;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_w_r = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [63:0] m_rdata;
    logic        m_rvalid, m_rready, m_rlast;
    logic        done, busy;
    logic [1:0]  done_resp;
    logic [2:0]  dbg_state;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion;
    logic [3:0]  m_axi_arcache, m_axi_arqos, m_axi_arregion;
    logic        m_axi_awlock, m_axi_arlock;
    logic [63:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wlast, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;

    axi_burst_master_stream dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_w_r(cmd_w_r),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
        .done(done), .done_resp(done_resp), .busy(busy), .dbg_state(dbg_state),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awprot(m_axi_awprot), .m_axi_awcache(m_axi_awcache), .m_axi_awlock(m_axi_awlock),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_arprot(m_axi_arprot), .m_axi_arcache(m_axi_arcache), .m_axi_arlock(m_axi_arlock),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    // Slave / stream behaviour knobs
    int          aw_delay = 0, ar_delay = 0, rr_mode = 0;
    bit          w_rand = 0, sw_rand = 0, r_rand = 0;
    logic [1:0]  bresp_tab[16];
    int          rerr_idx1 = -1, rerr_idx2 = -1;
    logic [1:0]  rerr_resp1 = 2'b00, rerr_resp2 = 2'b00;

    // Observation logs
    logic [31:0] aw_addr_log[$], ar_addr_log[$];
    logic [7:0]  aw_len_log[$], ar_len_log[$];
    logic [63:0] w_data_log[$], sent_q[$], rd_log[$];
    logic        w_last_log[$], rd_last_log[$];
    int          done_cnt = 0, stable_err = 0, mirror_err = 0;
    logic [1:0]  done_resp_log = 2'b00;

    // Slave state
    int          aw_wait = 0, ar_wait = 0, b_idx = 0, r_left = 0, r_idx = 0, s_seq = 0;
    bit          b_pending = 0, s_have = 0, aw_pend_prev = 0, ar_pend_prev = 0;
    logic [31:0] r_addr = '0, aw_prev_addr = '0, ar_prev_addr = '0;
    logic [7:0]  aw_prev_len = '0, ar_prev_len = '0;
    logic [63:0] s_cur = '0;

    // Reference model results
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hC0DE_F00D, a + 32'h1357_9BDF};
    endfunction

    function automatic logic [1:0] rresp_at(input int i);
        if (i == rerr_idx1) return rerr_resp1;
        if (i == rerr_idx2) return rerr_resp2;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave and user streams: drive on the falling edge, sample 1 ns later
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        s_wdata = 0; s_wstrb = '1; s_wvalid = 0; m_rready = 0;
        for (int i = 0; i < 16; i++) bresp_tab[i] = 2'b00;
        forever begin
            @(negedge aclk);
            cyc++;
            m_rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? (cyc % 3 == 0)
                                             : 1'($urandom_range(0, 1));
            if (!s_have) begin
                s_cur = {16'(s_seq), 16'($urandom), 32'($urandom)};
                s_seq++;
                s_have = 1;
            end
            s_wdata  = s_cur;
            s_wvalid = sw_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (areset) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
                aw_wait = 0; ar_wait = 0; b_pending = 0; r_left = 0;
                aw_pend_prev = 0; ar_pend_prev = 0;
            end else begin
                m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
                m_axi_wready  = w_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                m_axi_bvalid  = b_pending;
                m_axi_bresp   = bresp_tab[b_idx % 16];
                m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
                m_axi_rvalid  = (r_left != 0) && (r_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
                m_axi_rdata   = mem_word(r_addr);
                m_axi_rlast   = (r_left == 1);
                m_axi_rresp   = rresp_at(r_idx);
            end
            #1;
            if (!areset) begin
                if (m_axi_awvalid) begin
                    if (aw_pend_prev && (m_axi_awaddr !== aw_prev_addr || m_axi_awlen !== aw_prev_len))
                        stable_err++;
                    if (m_axi_awready) begin
                        aw_addr_log.push_back(m_axi_awaddr);
                        aw_len_log.push_back(m_axi_awlen);
                        aw_wait = 0; aw_pend_prev = 0;
                    end else begin
                        aw_wait++; aw_pend_prev = 1;
                        aw_prev_addr = m_axi_awaddr; aw_prev_len = m_axi_awlen;
                    end
                end else aw_pend_prev = 0;
                if (m_axi_wvalid && m_axi_wready) begin
                    w_data_log.push_back(m_axi_wdata);
                    w_last_log.push_back(m_axi_wlast);
                    if (m_axi_wlast) b_pending = 1;
                end
                if (s_wvalid && s_wready) begin
                    sent_q.push_back(s_wdata);
                    s_have = 0;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    b_pending = 0; b_idx++;
                end
                if (r_left != 0 && (m_axi_rready !== m_rready || m_rvalid !== m_axi_rvalid))
                    mirror_err++;
                if (m_axi_rvalid && m_axi_rready) begin
                    r_addr = r_addr + 32'd8; r_left--; r_idx++;
                end
                if (m_rvalid && m_rready) begin
                    rd_log.push_back(m_rdata);
                    rd_last_log.push_back(m_rlast);
                end
                if (m_axi_arvalid) begin
                    if (ar_pend_prev && (m_axi_araddr !== ar_prev_addr || m_axi_arlen !== ar_prev_len))
                        stable_err++;
                    if (m_axi_arready) begin
                        ar_addr_log.push_back(m_axi_araddr);
                        ar_len_log.push_back(m_axi_arlen);
                        r_addr = m_axi_araddr; r_left = int'(m_axi_arlen) + 1;
                        ar_wait = 0; ar_pend_prev = 0;
                    end else begin
                        ar_wait++; ar_pend_prev = 1;
                        ar_prev_addr = m_axi_araddr; ar_prev_len = m_axi_arlen;
                    end
                end else ar_pend_prev = 0;
                if (done) begin
                    done_cnt++;
                    done_resp_log = done_resp;
                end
            end
        end
    end

    task automatic clear_logs();
        aw_addr_log.delete(); aw_len_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
        w_data_log.delete(); w_last_log.delete(); sent_q.delete();
        rd_log.delete(); rd_last_log.delete();
        done_cnt = 0; b_idx = 0; r_idx = 0; stable_err = 0; mirror_err = 0;
    endtask

    task automatic run_cmd(input bit w_r, input logic [31:0] addr, input logic [15:0] beats);
        int n;
        n = 0;
        clear_logs();
        while (!cmd_ready && n < 100) begin
            @(posedge aclk); #2; n++;
        end
        cmd_w_r = w_r; cmd_addr = addr; cmd_beats = beats; cmd_valid = 1'b1;
        @(posedge aclk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(posedge aclk); #2; n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (4) @(posedge aclk);
        #2;
    endtask

    // Reference: split command into page-safe bursts and derive every expected beat.
    task automatic check_cmd(input string tag, input bit w_r, input logic [31:0] addr,
                             input int beats);
        logic [31:0] a;
        logic [1:0]  er;
        int rem, n, room, k;
        exp_addr_q.delete(); exp_len_q.delete(); exp_q.delete();
        a = addr & ~32'h7;
        rem = beats + 1;
        while (rem > 0) begin
            room = (4096 - int'(a % 32'd4096)) / 8;
            n = rem;
            if (n > 256) n = 256;
            if (n > room) n = room;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(8'(n - 1));
            a = a + 32'(n * 8);
            rem -= n;
        end
        er = 2'b00;
        if (w_r) begin
            for (int i = 0; i <= beats; i++)
                if (er == 2'b00 && rresp_at(i) >= 2'b10) er = rresp_at(i);
        end else begin
            for (int i = 0; i < exp_len_q.size(); i++)
                if (er == 2'b00 && bresp_tab[i % 16] >= 2'b10) er = bresp_tab[i % 16];
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_resp"}, 64'(done_resp_log), 64'(er));
        chk({tag, "_addr_stable"}, 64'(stable_err), 64'd0);
        if (w_r) begin
            chk({tag, "_n_ar"}, 64'(ar_addr_log.size()), 64'(exp_addr_q.size()));
            chk({tag, "_n_aw"}, 64'(aw_addr_log.size()), 64'd0);
            for (int i = 0; i < exp_addr_q.size() && i < ar_addr_log.size(); i++) begin
                chk($sformatf("%s_araddr[%0d]", tag, i), 64'(ar_addr_log[i]), 64'(exp_addr_q[i]));
                chk($sformatf("%s_arlen[%0d]", tag, i), 64'(ar_len_log[i]), 64'(exp_len_q[i]));
            end
            for (int i = 0; i <= beats; i++) exp_q.push_back(mem_word((addr & ~32'h7) + 32'(i * 8)));
            chk({tag, "_r_beats"}, 64'(rd_log.size()), 64'(beats + 1));
            chk({tag, "_rready_mirror"}, 64'(mirror_err), 64'd0);
            for (int i = 0; i <= beats && i < rd_log.size(); i++) begin
                chk($sformatf("%s_rdata[%0d]", tag, i), rd_log[i], exp_q[i]);
                chk($sformatf("%s_rlast[%0d]", tag, i), 64'(rd_last_log[i]), 64'(i == beats));
            end
        end else begin
            chk({tag, "_n_aw"}, 64'(aw_addr_log.size()), 64'(exp_addr_q.size()));
            chk({tag, "_n_ar"}, 64'(ar_addr_log.size()), 64'd0);
            chk({tag, "_n_b"}, 64'(b_idx), 64'(exp_addr_q.size()));
            for (int i = 0; i < exp_addr_q.size() && i < aw_addr_log.size(); i++) begin
                chk($sformatf("%s_awaddr[%0d]", tag, i), 64'(aw_addr_log[i]), 64'(exp_addr_q[i]));
                chk($sformatf("%s_awlen[%0d]", tag, i), 64'(aw_len_log[i]), 64'(exp_len_q[i]));
            end
            chk({tag, "_w_beats"}, 64'(w_data_log.size()), 64'(beats + 1));
            chk({tag, "_s_beats"}, 64'(sent_q.size()), 64'(beats + 1));
            k = 0;
            n = int'(exp_len_q[0]) + 1;
            for (int i = 0; i <= beats && i < w_data_log.size() && i < sent_q.size(); i++) begin
                chk($sformatf("%s_wdata[%0d]", tag, i), w_data_log[i], sent_q[i]);
                chk($sformatf("%s_wlast[%0d]", tag, i), 64'(w_last_log[i]), 64'(n == 1));
                n--;
                if (n == 0 && k + 1 < exp_len_q.size()) begin
                    k++;
                    n = int'(exp_len_q[k]) + 1;
                end
            end
        end
    endtask

    initial begin
        int n;
        bit wr;
        logic [31:0] ra;
        int rb;

        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_wlast", 64'(m_axi_wlast), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_s_wready", 64'(s_wready), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_done_resp", 64'(done_resp), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_awlen", 64'(m_axi_awlen), 64'd0);
        chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("awsize", 64'(m_axi_awsize), 64'd3);
        chk("arsize", 64'(m_axi_arsize), 64'd3);
        chk("awburst", 64'(m_axi_awburst), 64'd1);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("aw_side_consts", 64'({m_axi_awprot, m_axi_awcache, m_axi_awlock, m_axi_awqos, m_axi_awregion}), 64'd0);
        chk("ar_side_consts", 64'({m_axi_arprot, m_axi_arcache, m_axi_arlock, m_axi_arqos, m_axi_arregion}), 64'd0);
        #1 areset = 1'b0;
        @(posedge aclk); #2;

        // Single 4-beat write
        run_cmd(1'b0, 32'h1000, 16'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1");
        check_cmd("t1", 1'b0, 32'h1000, 3);

        // 300-beat write split by the burst cap
        run_cmd(1'b0, 32'h0, 16'd299);
        wait_done("t2");
        check_cmd("t2", 1'b0, 32'h0, 299);

        // Read crossing a 4 KB page
        run_cmd(1'b1, 32'hFE0, 16'd7);
        wait_done("t3");
        check_cmd("t3", 1'b1, 32'hFE0, 7);
        chk("t3_bursts", 64'(ar_addr_log.size()), 64'd2);

        // Read with user backpressure and a slow address channel
        rr_mode = 1; ar_delay = 5;
        run_cmd(1'b1, 32'h3000, 16'd20);
        wait_done("t4");
        check_cmd("t4", 1'b1, 32'h3000, 20);
        rr_mode = 0; ar_delay = 0;

        // Two-burst write: EXOKAY then SLVERR
        bresp_tab[0] = 2'b01; bresp_tab[1] = 2'b10;
        run_cmd(1'b0, 32'h5FF0, 16'd5);
        wait_done("t5");
        check_cmd("t5", 1'b0, 32'h5FF0, 5);
        chk("t5_resp_const", 64'(done_resp_log), 64'd2);
        bresp_tab[0] = 2'b00; bresp_tab[1] = 2'b00;

        // Read with DECERR then SLVERR: the first error is kept
        rerr_idx1 = 2; rerr_resp1 = 2'b11; rerr_idx2 = 6; rerr_resp2 = 2'b10;
        run_cmd(1'b1, 32'h7000, 16'd9);
        wait_done("t6");
        check_cmd("t6", 1'b1, 32'h7000, 9);
        chk("t6_resp_const", 64'(done_resp_log), 64'd3);
        rerr_idx1 = -1; rerr_idx2 = -1;

        // Reset in the middle of a write burst
        run_cmd(1'b0, 32'h2000, 16'd3);
        n = 0;
        while (w_data_log.size() < 1 && n < 200) begin
            @(posedge aclk); #2; n++;
        end
        chk("t7_first_beat", 64'(w_data_log.size()), 64'd1);
        areset = 1'b1;
        @(posedge aclk); #1;
        chk("t7_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("t7_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("t7_s_wready", 64'(s_wready), 64'd0);
        #1 areset = 1'b0;
        @(posedge aclk); #2;
        run_cmd(1'b0, 32'h2000, 16'd3);
        wait_done("t7b");
        check_cmd("t7b", 1'b0, 32'h2000, 3);

        // Randomised commands, handshake timing and response errors
        for (int t = 0; t < 8; t++) begin
            wr = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom_range(0, 520);
            aw_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            w_rand = 1'($urandom_range(0, 1)); sw_rand = 1'($urandom_range(0, 1));
            r_rand = 1'($urandom_range(0, 1)); rr_mode = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++)
                bresp_tab[i] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            rerr_idx1 = $urandom_range(0, 700); rerr_resp1 = 2'($urandom_range(0, 3));
            rerr_idx2 = $urandom_range(0, 700); rerr_resp2 = 2'($urandom_range(0, 3));
            run_cmd(wr, ra, 16'(rb));
            wait_done($sformatf("r%0d", t));
            check_cmd($sformatf("r%0d", t), wr, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
